cache_main_memory: RTL

- Block-oriented main-memory model and controller sitting directly downstream of the cache controller.
- Services line fills (read) and dirty-line write-backs (write) over a valid/ready request port and a single-cycle response pulse.
- Fixed, parameterised access latency.
- One outstanding request at a time.

---
 rtl/cache_main_memory_if.sv | 25 ++
 rtl/cache_main_memory.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cache_main_memory_if.sv
// Request/response bus between the cache controller (master) and main memory (slave).
// Line data packs word k at bits [32k+31:32k].
interface cache_main_memory_if #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 4
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_addr;
  logic [32*BLOCK_WORDS-1:0]   req_wdata;
  logic                        resp_valid;
  logic                        resp_we;
  logic [32*BLOCK_WORDS-1:0]   resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_we, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_we, resp_rdata
  );
endinterface

// File: rtl/cache_main_memory.sv
// Line-oriented main memory: one outstanding fill or write-back, fixed latency,
// single-cycle response pulse. Array powers up holding mem[i] = i.
module cache_main_memory #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  cache_main_memory_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LINE_W = 32 * BLOCK_WORDS;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               accept_s;
  logic               commit_s;
  logic [ADDR_W-1:0]  base_r;
  logic               we_r;
  logic [LINE_W-1:0]  wdata_r;
  logic [LINE_W-1:0]  line_s;
  logic [LINE_W-1:0]  rdata_r;
  logic               resp_valid_r;
  logic               resp_we_r;

  // Words are stored XORed with their address, so an all-zero array reads as mem[i] = i.
  logic [31:0] mem_r [DEPTH];

  function automatic logic [31:0] addr_key(input logic [ADDR_W-1:0] a);
    return 32'(a);
  endfunction

  assign bus.req_ready  = (state_r == IDLE) && reset;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_we    = resp_we_r;
  assign bus.resp_rdata = rdata_r;

  // Next-state and latency countdown
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          state_s  = BUSY;
          cnt_s    = CNT_LOAD;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          state_s  = RESP;
          commit_s = 1'b1;
        end else begin
          cnt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request capture and registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      base_r       <= {ADDR_W{1'b0}};
      we_r         <= 1'b0;
      wdata_r      <= {LINE_W{1'b0}};
      rdata_r      <= {LINE_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_we_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        base_r  <= bus.req_addr & ~OFF_MASK;
        we_r    <= bus.req_we;
        wdata_r <= bus.req_wdata;
      end
      // Write responses leave the last fill data visible
      if (commit_s && !we_r) begin
        rdata_r <= line_s;
      end
      resp_valid_r <= commit_s;
      resp_we_r    <= commit_s ? we_r : 1'b0;
    end
  end

  // Write-back commit; aligned base means base+k never wraps past the top line
  always_ff @(posedge clk) begin
    if (reset && commit_s && we_r) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        mem_r[base_r + ADDR_W'(k)] <= wdata_r[32*k +: 32] ^ addr_key(base_r + ADDR_W'(k));
      end
    end
  end

  // Line read from the array
  always_comb begin
    line_s = {LINE_W{1'b0}};
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      line_s[32*k +: 32] = mem_r[base_r + ADDR_W'(k)] ^ addr_key(base_r + ADDR_W'(k));
    end
  end

endmodule
